// File: rtl/dmem_bus_pkg.sv
// dmem_bus_pkg: shared types and constants for the data-memory bus interface.
// Provides FSM states, RV32 load/store funct3 codes, bus SIZE codes, fault bits and access checks.
package dmem_bus_pkg;

   // Bus-side FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // RV32 load/store funct3 encodings (stores share B/H/W codes).
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Bus SIZE codes.
   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   // Fault bit positions in resp_fault and the matching masks.
   localparam int         FLT_MISALIGN = 0;
   localparam int         FLT_TIMEOUT  = 1;
   localparam logic [1:0] FLT_MIS_M    = 2'b01 << FLT_MISALIGN;
   localparam logic [1:0] FLT_TMO_M    = 2'b01 << FLT_TIMEOUT;

   // True when the access must not reach the bus: a misaligned address,
   // or a funct3 that is not a legal load/store (unsigned stores included).
   function automatic logic access_bad(
      input logic       wr,
      input logic [2:0] f3,
      input logic [1:0] a
   );
      logic bad;
      case (f3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = a[0];
         F3_W:    bad = |a;
         F3_BU:   bad = wr;
         F3_HU:   bad = wr | a[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Bus SIZE for a legal funct3; the width lives in the low two bits.
   function automatic logic [1:0] size_of(input logic [2:0] f3);
      logic [1:0] sz;
      case (f3[1:0])
         2'b00:   sz = SZ_BYTE;
         2'b01:   sz = SZ_HALF;
         default: sz = SZ_WORD;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering between core (little-endian) and bus (big-endian).
// Ports: i_funct3, i_st_data (core store data), i_bus_data (DDT) -> o_bus_wdata, o_size, o_ld_data.
module dmem_lane_align
   import dmem_bus_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_st_data,
   input  logic [31:0] i_bus_data,
   output logic [31:0] o_bus_wdata,
   output logic [1:0]  o_size,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_st_swap;
   logic [31:0] w_ld_swap;
   logic [15:0] w_ld_half;
   logic [7:0]  w_ld_byte;

   // The bus numbers bytes from the MSB, so a word is a full byte reversal
   // and a half is a swap within the low 16 bits.
   assign w_st_swap = {i_st_data[7:0],   i_st_data[15:8],
                       i_st_data[23:16], i_st_data[31:24]};
   assign w_ld_swap = {i_bus_data[7:0],   i_bus_data[15:8],
                       i_bus_data[23:16], i_bus_data[31:24]};
   assign w_ld_half = {i_bus_data[7:0], i_bus_data[15:8]};
   assign w_ld_byte = i_bus_data[7:0];

   assign o_size = size_of(i_funct3);

   always_comb begin
      o_bus_wdata = '0;
      case (i_funct3[1:0])
         2'b00:   o_bus_wdata = {24'h0, i_st_data[7:0]};
         2'b01:   o_bus_wdata = {16'h0, i_st_data[7:0], i_st_data[15:8]};
         default: o_bus_wdata = w_st_swap;
      endcase
   end

   always_comb begin
      o_ld_data = '0;
      case (i_funct3)
         F3_B:    o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         F3_BU:   o_ld_data = {24'h0, w_ld_byte};
         F3_H:    o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         F3_HU:   o_ld_data = {16'h0, w_ld_half};
         F3_W:    o_ld_data = w_ld_swap;
         default: o_ld_data = '0;
      endcase
   end

endmodule

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: MEM-stage load/store unit driving the external DAD/DDT/MREQ/WRITE/SIZE/ACKD_n bus.
// Ports: req_* handshake in, resp_* pulse out, bus pins; rst is async active-low.
module dmem_bus_if
   import dmem_bus_pkg::*;
#(
   parameter int BIT_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 256
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [2:0]           req_funct3,
   input  logic [BIT_WIDTH-1:0] req_addr,
   input  logic [BIT_WIDTH-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [BIT_WIDTH-1:0] resp_rdata,
   output logic [1:0]           resp_fault,
   output logic [BIT_WIDTH-1:0] DAD,
   inout  wire  [BIT_WIDTH-1:0] DDT,
   output logic                 MREQ,
   output logic                 WRITE,
   output logic [1:0]           SIZE,
   input  logic                 ACKD_n
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t               r_state;
   logic                 r_req_ready;
   logic                 r_resp_valid;
   logic [BIT_WIDTH-1:0] r_resp_rdata;
   logic [1:0]           r_resp_fault;
   logic [BIT_WIDTH-1:0] r_dad;
   logic [BIT_WIDTH-1:0] r_ddt_out;
   logic                 r_ddt_oe;
   logic                 r_mreq;
   logic                 r_bus_write;
   logic [1:0]           r_size;
   logic                 r_write;
   logic [2:0]           r_funct3;
   logic [CW-1:0]        r_cnt;

   logic [2:0]           w_f3;
   logic [BIT_WIDTH-1:0] w_st_lanes;
   logic [BIT_WIDTH-1:0] w_ld_data;
   logic [1:0]           w_size;
   logic                 w_bad;

   // In IDLE the lane logic looks at the incoming request (store lanes and
   // SIZE are registered on accept); afterwards it follows the latched
   // funct3 so load extension is right when the ack arrives.
   assign w_f3  = (r_state == ST_IDLE) ? req_funct3 : r_funct3;
   assign w_bad = access_bad(req_write, req_funct3, req_addr[1:0]);

   dmem_lane_align u_lane (
      .i_funct3    (w_f3),
      .i_st_data   (req_wdata),
      .i_bus_data  (DDT),
      .o_bus_wdata (w_st_lanes),
      .o_size      (w_size),
      .o_ld_data   (w_ld_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_fault <= '0;
         r_dad        <= '0;
         r_ddt_out    <= '0;
         r_ddt_oe     <= 1'b0;
         r_mreq       <= 1'b0;
         r_bus_write  <= 1'b0;
         r_size       <= SZ_WORD;
         r_write      <= 1'b0;
         r_funct3     <= '0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_funct3    <= req_funct3;
                  r_write     <= req_write;
                  r_cnt       <= '0;
                  r_req_ready <= 1'b0;
                  if (w_bad) begin
                     // Fault straight away; the bus is never touched.
                     r_state      <= ST_DONE;
                     r_resp_valid <= 1'b1;
                     r_resp_fault <= FLT_MIS_M;
                     r_resp_rdata <= '0;
                  end else begin
                     r_state     <= ST_BUS;
                     r_mreq      <= 1'b1;
                     r_dad       <= req_addr;
                     r_bus_write <= req_write;
                     r_size      <= w_size;
                     r_ddt_out   <= w_st_lanes;
                     r_ddt_oe    <= req_write;
                  end
               end
            end
            ST_BUS: begin
               if (!ACKD_n) begin
                  r_state      <= ST_DONE;
                  r_mreq       <= 1'b0;
                  r_bus_write  <= 1'b0;
                  r_ddt_oe     <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_fault <= '0;
                  r_resp_rdata <= r_write ? '0 : w_ld_data;
               end else if (r_cnt == CNT_LAST) begin
                  // Ack never came within the window: abandon the cycle.
                  r_state      <= ST_DONE;
                  r_mreq       <= 1'b0;
                  r_bus_write  <= 1'b0;
                  r_ddt_oe     <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_fault <= FLT_TMO_M;
                  r_resp_rdata <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_resp_valid <= 1'b0;
               r_resp_fault <= '0;
               r_resp_rdata <= '0;
               r_req_ready  <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
               r_mreq      <= 1'b0;
               r_ddt_oe    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_fault = r_resp_fault;
   assign DAD        = r_dad;
   assign MREQ       = r_mreq;
   assign WRITE      = r_bus_write;
   assign SIZE       = r_size;
   assign DDT        = r_ddt_oe ? r_ddt_out : 'z;

endmodule

// File: tb/tb_dmem_bus_if.sv
// tb_dmem_bus_if: directed + random load/store traffic against a byte-level reference model.
// Bus slave is emulated inline; DDT release is observed by driving patterns onto the shared net.
module tb_dmem_bus_if;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_fault;
   logic [31:0] DAD;
   wire  [31:0] DDT;
   logic        MREQ;
   logic        WRITE;
   logic [1:0]  SIZE;
   logic        ACKD_n;
   logic [31:0] tb_ddt;
   logic        tb_oe;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign DDT = tb_oe ? tb_ddt : 'z;

   dmem_bus_if #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .DAD        (DAD),
      .DDT        (DDT),
      .MREQ       (MREQ),
      .WRITE      (WRITE),
      .SIZE       (SIZE),
      .ACKD_n     (ACKD_n)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---- reference model: byte-level rules ----
   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit m_bad(input bit wr, input logic [2:0] f3,
                                input logic [31:0] a);
      bit ok;
      if (wr) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2)
                || (f3 == 3'd4) || (f3 == 3'd5);
      if (!ok) return 1'b1;
      return (a % nbytes(f3)) != 0;
   endfunction

   // Bus byte (n-1-i) carries core byte i.
   function automatic logic [31:0] m_st(input logic [2:0] f3,
                                        input logic [31:0] wd);
      logic [31:0] r;
      int n;
      r = '0;
      n = nbytes(f3);
      for (int i = 0; i < n; i++) r[8*(n-1-i) +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_ld(input logic [2:0] f3,
                                        input logic [31:0] d);
      logic [31:0] r;
      int n;
      r = '0;
      n = nbytes(f3);
      for (int i = 0; i < n; i++) r[8*i +: 8] = d[8*(n-1-i) +: 8];
      if (n < 4 && !f3[2] && r[8*n-1])
         for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
      return r;
   endfunction

   function automatic logic [1:0] m_size(input logic [2:0] f3);
      int n;
      n = nbytes(f3);
      return (n == 4) ? 2'b00 : (n == 2) ? 2'b01 : 2'b10;
   endfunction

   task automatic ddt_released(input string tag);
      tb_oe  = 1'b1;
      tb_ddt = 32'h5AC3_3CA5;
      #1 chk(tag, DDT, 32'h5AC3_3CA5);
      tb_ddt = 32'hA53C_C35A;
      #1 chk(tag, DDT, 32'hA53C_C35A);
      tb_oe = 1'b0;
      #1;
   endtask

   // One full access starting and ending at a negedge in IDLE.
   // dly = number of non-ack bus cycles before ACKD_n goes low.
   task automatic access(input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int dly, input logic [31:0] busd,
                         input bit noise);
      bit          b;
      int          exp_cyc;
      int          cyc;
      logic [1:0]  exp_flt;
      logic [31:0] exp_rd;
      b       = m_bad(wr, f3, a);
      exp_cyc = b ? 0 : ((dly < T) ? dly + 1 : T);
      exp_flt = b ? 2'b01 : ((dly < T) ? 2'b00 : 2'b10);
      exp_rd  = (b || wr || dly >= T) ? 32'h0 : m_ld(f3, busd);
      chk("idle_ready", 32'(req_ready), 32'h1);
      chk("idle_rv", 32'(resp_valid), 32'h0);
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(negedge clk);
      // Optionally keep junk on the request port while busy; it must be ignored.
      req_valid  = noise;
      req_funct3 = noise ? 3'b011 : f3;
      req_addr   = $urandom;
      req_write  = 1'($urandom);
      req_wdata  = $urandom;
      cyc = 0;
      while (MREQ === 1'b1 && cyc < T + 2) begin
         chk("bus_dad", DAD, a);
         chk("bus_write", 32'(WRITE), 32'(wr));
         chk("bus_size", 32'(SIZE), 32'(m_size(f3)));
         chk("bus_ready", 32'(req_ready), 32'h0);
         chk("bus_rv", 32'(resp_valid), 32'h0);
         if (wr) chk("bus_ddt", DDT, m_st(f3, wd));
         ACKD_n = (cyc == dly) ? 1'b0 : 1'b1;
         tb_oe  = !wr;
         tb_ddt = busd;
         cyc++;
         @(negedge clk);
      end
      ACKD_n    = 1'b1;
      tb_oe     = 1'b0;
      req_valid = 1'b0;
      chk("mreq_cycles", 32'(cyc), 32'(exp_cyc));
      chk("done_rv", 32'(resp_valid), 32'h1);
      chk("done_fault", 32'(resp_fault), 32'(exp_flt));
      chk("done_rdata", resp_rdata, exp_rd);
      chk("done_ready", 32'(req_ready), 32'h0);
      chk("done_mreq", 32'(MREQ), 32'h0);
      ddt_released("done_ddt_z");
      @(negedge clk);
      chk("rv_pulse", 32'(resp_valid), 32'h0);
      chk("ready_back", 32'(req_ready), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = '0;
      req_wdata  = '0;
      ACKD_n     = 1'b1;
      tb_oe      = 1'b0;
      tb_ddt     = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h1);
      chk("rst_mreq", 32'(MREQ), 32'h0);
      chk("rst_write", 32'(WRITE), 32'h0);
      chk("rst_size", 32'(SIZE), 32'h0);
      chk("rst_dad", DAD, 32'h0);
      chk("rst_rv", 32'(resp_valid), 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_fault", 32'(resp_fault), 32'h0);
      ddt_released("rst_ddt_z");
      rst = 1'b1;
      @(negedge clk);

      // LW, immediate ack: rdata 0x44332211
      access(1'b0, 3'b010, 32'h0800_0000, 32'h0, 0, 32'h1122_3344, 1'b0);
      // LB / LBU of 0x80
      access(1'b0, 3'b000, 32'h0800_0005, 32'h0, 0, 32'h1234_5680, 1'b0);
      access(1'b0, 3'b100, 32'h0800_0005, 32'h0, 1, 32'h1234_5680, 1'b0);
      // LH / LHU sign handling
      access(1'b0, 3'b001, 32'h0800_0002, 32'h0, 0, 32'hAAAA_0080, 1'b0);
      access(1'b0, 3'b101, 32'h0800_0002, 32'h0, 2, 32'hAAAA_0080, 1'b0);
      // SH 0xBEEF -> DDT 0x0000EFBE
      access(1'b1, 3'b001, 32'h0800_0002, 32'h0000_BEEF, 0, 32'h0, 1'b0);
      // Misaligned LW, misaligned SH, invalid store funct3
      access(1'b0, 3'b010, 32'h0800_0002, 32'h0, 0, 32'h0, 1'b0);
      access(1'b1, 3'b001, 32'h0800_0001, 32'h1234, 0, 32'h0, 1'b0);
      access(1'b1, 3'b100, 32'h0800_0000, 32'h1234, 0, 32'h0, 1'b0);
      // SW with 3 wait cycles: last legal ack position
      access(1'b1, 3'b010, 32'h0800_0010, 32'hCAFE_F00D, 3, 32'h0, 1'b1);
      // Never acked: timeout
      access(1'b1, 3'b010, 32'h0800_0014, 32'hDEAD_BEEF, 99, 32'h0, 1'b0);
      access(1'b0, 3'b010, 32'h0800_0018, 32'h0, T, 32'h5555_AAAA, 1'b0);
      // stdout / exit addresses are ordinary stores
      access(1'b1, 3'b000, 32'hF000_0000, 32'h0000_0041, 0, 32'h0, 1'b0);
      access(1'b1, 3'b010, 32'hFF00_0000, 32'h0000_0001, 1, 32'h0, 1'b0);

      // Reset in the middle of a bus cycle aborts it with no response.
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0800_0020;
      req_wdata  = 32'h0BAD_CAFE;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_pre_mreq", 32'(MREQ), 32'h1);
      #1 rst = 1'b0;
      #1;
      chk("abort_mreq", 32'(MREQ), 32'h0);
      chk("abort_ready", 32'(req_ready), 32'h1);
      chk("abort_rv", 32'(resp_valid), 32'h0);
      ddt_released("abort_ddt_z");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_resp", 32'(resp_valid), 32'h0);
         chk("abort_idle_mreq", 32'(MREQ), 32'h0);
      end
      access(1'b0, 3'b010, 32'h0800_0024, 32'h0, 0, 32'h0102_0304, 1'b0);

      // Random traffic
      for (int k = 0; k < 40; k++) begin
         bit          wr;
         logic [2:0]  f3;
         logic [31:0] a;
         wr = 1'($urandom);
         f3 = 3'($urandom_range(0, 7));
         a  = 32'h0800_0000 | ($urandom & 32'h0000_0FFF);
         if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
         access(wr, f3, a, $urandom, int'($urandom_range(0, T + 1)),
                $urandom, 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
